// File: rtl/hamming_serial_rx_if.sv
// rtl/hamming_serial_rx_if.sv - serial code-bit input and decoded-frame output bundle
interface hamming_serial_rx_if #(
  parameter int CNT_W = 8
);
  logic             rx_bit;
  logic             rx_valid;
  logic             rx_sof;
  logic [3:0]       data_out;
  logic [6:0]       code_out;
  logic [2:0]       syndrome;
  logic             corrected;
  logic             data_valid;
  logic             data_ready;
  logic [CNT_W-1:0] corr_count;
  logic             overflow;
  logic             frame_abort;

  modport master (
    output rx_bit, rx_valid, rx_sof, data_ready,
    input  data_out, code_out, syndrome, corrected, data_valid,
    input  corr_count, overflow, frame_abort
  );

  modport slave (
    input  rx_bit, rx_valid, rx_sof, data_ready,
    output data_out, code_out, syndrome, corrected, data_valid,
    output corr_count, overflow, frame_abort
  );
endinterface

// File: rtl/hamming_serial_rx.sv
// rtl/hamming_serial_rx.sv - bit-serial Hamming(7,4) deserializer, corrector and output register
module hamming_serial_rx #(
  parameter int CNT_W = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  hamming_serial_rx_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [5:0]       r_bits, w_bits_nxt;
  logic             w_complete, w_abort, w_load;
  logic [6:0]       w_code, w_fixed;
  logic [2:0]       w_syn;
  logic [3:0]       w_data;

  logic [3:0]       r_data_out;
  logic [6:0]       r_code_out;
  logic [2:0]       r_syndrome;
  logic             r_corrected, r_data_valid, r_overflow, r_frame_abort;
  logic [CNT_W-1:0] r_corr_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // An sof bit always wins: it restarts collection even when it would be the 7th bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bits_nxt  = r_bits;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid && bus.rx_sof) begin
          w_state_nxt = ST_COLLECT;
          w_cnt_nxt   = 3'd1;
          w_bits_nxt  = {5'b0, bus.rx_bit};
        end
      end
      ST_COLLECT: begin
        if (bus.rx_valid) begin
          if (bus.rx_sof) begin
            w_abort    = 1'b1;
            w_cnt_nxt  = 3'd1;
            w_bits_nxt = {5'b0, bus.rx_bit};
          end else if (r_cnt == 3'd6) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_bits_nxt[r_cnt] = bus.rx_bit;
            w_cnt_nxt         = r_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_code = {bus.rx_bit, r_bits};
  assign w_syn  = {w_code[3] ^ w_code[4] ^ w_code[5] ^ w_code[6],
                   w_code[1] ^ w_code[2] ^ w_code[5] ^ w_code[6],
                   w_code[0] ^ w_code[2] ^ w_code[4] ^ w_code[6]};
  assign w_fixed = (w_syn == 3'd0) ? w_code : (w_code ^ (7'd1 << (w_syn - 3'd1)));
  assign w_data  = {w_fixed[6:4], w_fixed[2]};
  assign w_load  = w_complete && (!r_data_valid || bus.data_ready);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt         <= 3'd0;
      r_bits        <= 6'd0;
      r_data_out    <= 4'd0;
      r_code_out    <= 7'd0;
      r_syndrome    <= 3'd0;
      r_corrected   <= 1'b0;
      r_data_valid  <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_abort <= 1'b0;
      r_corr_count  <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_bits <= w_bits_nxt;
      if (w_load) begin
        r_data_out   <= w_data;
        r_code_out   <= w_code;
        r_syndrome   <= w_syn;
        r_corrected  <= (w_syn != 3'd0);
        r_data_valid <= 1'b1;
      end else if (r_data_valid && bus.data_ready) begin
        r_data_valid <= 1'b0;
      end
      if (w_complete && !w_load) r_overflow <= 1'b1;
      if (w_abort) r_frame_abort <= 1'b1;
      // Dropped frames still count: the counter tracks channel errors, not deliveries.
      if (w_complete && (w_syn != 3'd0) && (r_corr_count != CNT_MAX))
        r_corr_count <= r_corr_count + CNT_ONE;
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.code_out    = r_code_out;
  assign bus.syndrome    = r_syndrome;
  assign bus.corrected   = r_corrected;
  assign bus.data_valid  = r_data_valid;
  assign bus.corr_count  = r_corr_count;
  assign bus.overflow    = r_overflow;
  assign bus.frame_abort = r_frame_abort;
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb/tb_hamming_serial_rx.sv - scoreboard bench for hamming_serial_rx against a positional-XOR reference
module tb_hamming_serial_rx;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic [3:0] data;
    logic [6:0] code;
    logic [2:0] syn;
    logic       corr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  exp_t sb[$];
  logic frame[$];
  int   m_corr = 0;
  logic m_valid = 1'b0;
  logic m_ovf = 1'b0;
  logic m_abort = 1'b0;

  hamming_serial_rx_if #(.CNT_W(CNT_W)) bus ();

  hamming_serial_rx #(.CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Parity bits are chosen so the XOR of the positions of all set bits is zero.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] c;
    int dpos[4];
    int s;
    dpos = '{3, 5, 6, 7};
    c = '0;
    s = 0;
    for (int i = 0; i < 4; i++) if (d[i]) begin
      c[dpos[i]-1] = 1'b1;
      s ^= dpos[i];
    end
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    return c;
  endfunction

  function automatic exp_t ref_decode(input logic [6:0] c);
    exp_t e;
    logic [6:0] f;
    int s;
    s = 0;
    for (int i = 1; i <= 7; i++) if (c[i-1]) s ^= i;
    f = c;
    if (s != 0) f[s-1] = ~f[s-1];
    e.data = {f[6], f[5], f[4], f[2]};
    e.code = c;
    e.syn  = s[2:0];
    e.corr = (s != 0);
    return e;
  endfunction

  task automatic step(input logic v, input logic s, input logic b, input logic rdy);
    logic complete, load;
    logic [6:0] code;
    exp_t e;
    complete = 1'b0;
    load = 1'b0;
    code = '0;
    if (v) begin
      if (s) begin
        if (frame.size() != 0) m_abort = 1'b1;
        frame.delete();
        frame.push_back(b);
      end else if (frame.size() != 0) begin
        frame.push_back(b);
        if (frame.size() == 7) begin
          complete = 1'b1;
          for (int i = 0; i < 7; i++) code[i] = frame[i];
          frame.delete();
        end
      end
    end
    if (complete) begin
      e = ref_decode(code);
      if (e.corr && m_corr < CMAX) m_corr++;
      load = !m_valid || rdy;
      if (load) sb.push_back(e);
      else m_ovf = 1'b1;
    end
    m_valid = load ? 1'b1 : ((m_valid && rdy) ? 1'b0 : m_valid);
    bus.rx_valid = v;
    bus.rx_sof = s;
    bus.rx_bit = b;
    bus.data_ready = rdy;
    @(posedge clk);
    #1;
    chk("data_valid", bus.data_valid, m_valid);
    chk("corr_count", bus.corr_count, m_corr);
    chk("overflow", bus.overflow, m_ovf);
    chk("frame_abort", bus.frame_abort, m_abort);
  endtask

  task automatic send_frame(input logic [6:0] code, input logic rdy_body, input logic rdy_last);
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, code[i], (i == 6) ? rdy_last : rdy_body);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_code_out", bus.code_out, 0);
    chk("rst_syndrome", bus.syndrome, 0);
    chk("rst_corrected", bus.corrected, 0);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_corr_count", bus.corr_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_frame_abort", bus.frame_abort, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_reset_outputs();
    sb.delete();
    frame.delete();
    m_corr = 0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_abort = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.data_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        e = sb[0];
        chk("mon_data_out", bus.data_out, e.data);
        chk("mon_code_out", bus.code_out, e.code);
        chk("mon_syndrome", bus.syndrome, e.syn);
        chk("mon_corrected", bus.corrected, e.corr);
        if (bus.data_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [6:0] c;
    logic [3:0] d;
    bus.rx_bit = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_sof = 1'b0;
    bus.data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    send_frame(7'h55, 1'b1, 1'b1);
    chk("clean_data", bus.data_out, 4'b1011);
    chk("clean_syn", bus.syndrome, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clean_one_cycle", bus.data_valid, 0);

    for (int p = 1; p <= 7; p++) begin
      c = 7'h55 ^ (7'd1 << (p - 1));
      send_frame(c, 1'b1, 1'b1);
      chk("err_syn_pos", bus.syndrome, p);
      chk("err_data", bus.data_out, 4'b1011);
      chk("err_code", bus.code_out, c);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("sat_count", bus.corr_count, 3);

    c = 7'h55;
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, c[i], 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 3; i < 7; i++) step(1'b1, 1'b0, c[i], 1'b1);
    chk("stall_data", bus.data_out, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, c[i], 1'b1);
    send_frame(7'h55, 1'b1, 1'b1);
    chk("abort_flag", bus.frame_abort, 1);
    chk("abort_data", bus.data_out, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    send_frame(ref_encode(4'h6), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(ref_encode(4'h9), 1'b0, 1'b1);
    chk("replace_valid", bus.data_valid, 1);
    chk("replace_data", bus.data_out, 4'h9);
    chk("replace_ovf", bus.overflow, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    do_reset();
    send_frame(7'h55, 1'b0, 1'b0);
    send_frame(7'h45, 1'b0, 1'b0);
    chk("bp_ovf", bus.overflow, 1);
    chk("bp_count", bus.corr_count, 1);
    chk("bp_held", bus.data_out, 4'b1011);
    chk("bp_syn", bus.syndrome, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
             $urandom_range(0, 3) != 0);
      end else begin
        d = 4'($urandom_range(0, 15));
        c = ref_encode(d);
        for (int k = $urandom_range(0, 2); k > 0; k--) c[$urandom_range(0, 6)] ^= 1'b1;
        for (int i = 0; i < 7; i++) begin
          if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
          step(1'b1, i == 0, c[i], $urandom_range(0, 3) != 0);
        end
      end
    end

    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b1);
    c = ref_encode(4'hc) ^ 7'h04;
    send_frame(c, 1'b1, 1'b1);
    chk("post_rst_data", bus.data_out, 4'hc);
    chk("post_rst_syn", bus.syndrome, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
